// File: rtl/multicycle_state_ctrl_if.sv
// Control-side bundle between the multicycle next-state controller and its
// environment: IR opcode and memory/resume handshakes in, state and debug counters out.
interface multicycle_state_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             InsReady;
    logic             MemReady;
    logic             Resume;
    logic [2:0]       state;
    logic             Halted;
    logic             IllegalOp;
    logic [CNT_W-1:0] CycleCount;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        output opcode, InsReady, MemReady, Resume,
        input  state, Halted, IllegalOp, CycleCount, RetireCount
    );

    modport slave (
        input  opcode, InsReady, MemReady, Resume,
        output state, Halted, IllegalOp, CycleCount, RetireCount
    );
endinterface

// File: rtl/multicycle_state_ctrl.sv
// Next-state controller for the multicycle CPU: sequences IF/ID/EXE/MEM/WB,
// stalls on memory ready, latches halt/illegal flags and keeps debug counters.
module multicycle_state_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    multicycle_state_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_AEXE = 3'b110,
        S_BEXE = 3'b101,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_AWB  = 3'b111,
        S_CWB  = 3'b100
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010,
                           OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010,
                           OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111,
                           OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100,
                           OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010,
                           OP_HALT = 6'b111111;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             retire;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IF;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        // Halted is only ever set on the way into IF, so clearing it here
        // never races with the set in ID.
        if (halted_q && bus.Resume) halted_d = 1'b0;
        case (state_q)
            S_IF:   if (!halted_q && bus.InsReady) state_d = S_ID;
            S_ID: begin
                case (bus.opcode)
                    OP_J, OP_JR, OP_JAL: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_IF;
                        retire   = 1'b1;
                        halted_d = 1'b1;
                    end
                    OP_BEQ:       state_d = S_BEXE;
                    OP_SW, OP_LW: state_d = S_CEXE;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                    OP_SLL, OP_SLT, OP_SLTI: state_d = S_AEXE;
                    default: begin
                        state_d   = S_IF;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_AEXE: state_d = S_AWB;
            S_CEXE: state_d = S_MEM;
            S_MEM: begin
                if (bus.MemReady) begin
                    if (bus.opcode == OP_LW) begin
                        state_d = S_CWB;
                    end else begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end
            end
            S_AWB, S_BEXE, S_CWB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        cycle_d  = halted_q ? cycle_q : cycle_q + CNT_W'(1);
        retire_d = retire ? retire_q + CNT_W'(1) : retire_q;
    end

    assign bus.state       = state_q;
    assign bus.Halted      = halted_q;
    assign bus.IllegalOp   = illegal_q;
    assign bus.CycleCount  = cycle_q;
    assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_multicycle_state_ctrl.sv
// Bench for multicycle_state_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a per-instruction plan-queue reference model.
module tb_multicycle_state_ctrl;
    localparam int CNT_W = 32;
    localparam logic [2:0] IF_ = 3'b000, ID_ = 3'b001, AEXE = 3'b110, BEXE = 3'b101,
                           CEXE = 3'b010, MEM_ = 3'b011, AWB = 3'b111, CWB = 3'b100;

    logic CLK;
    logic Reset;
    multicycle_state_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_state_ctrl #(.CNT_W(CNT_W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: at ID the opcode expands into the list of states still
    // to visit; the instruction retires when that list runs out.
    logic [2:0]       m_state;
    logic             m_halted, m_illegal;
    logic [CNT_W-1:0] m_cyc, m_ret;
    logic [2:0]       plan[$];

    logic [5:0] legal_ops [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                   6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
                                   6'b110001, 6'b110100, 6'b111000, 6'b111001, 6'b111010,
                                   6'b111111};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (Reset) begin
            m_state = IF_; m_halted = 0; m_illegal = 0; m_cyc = 0; m_ret = 0;
            plan.delete();
            return;
        end
        if (!m_halted) m_cyc = m_cyc + 1;
        if (m_state == IF_) begin
            if (m_halted) begin
                if (bus.Resume) m_halted = 0;
            end else if (bus.InsReady) m_state = ID_;
        end else if (m_state == ID_) begin
            plan.delete();
            case (bus.opcode)
                6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                6'b011000, 6'b100110, 6'b100111: plan = '{AEXE, AWB};
                6'b110100: plan = '{BEXE};
                6'b110000: plan = '{CEXE, MEM_};
                6'b110001: plan = '{CEXE, MEM_, CWB};
                6'b111000, 6'b111001, 6'b111010: begin m_ret = m_ret + 1; end
                6'b111111: begin m_ret = m_ret + 1; m_halted = 1; end
                default:   m_illegal = 1;
            endcase
            m_state = (plan.size() != 0) ? plan.pop_front() : IF_;
        end else if (m_state == MEM_ && !bus.MemReady) begin
            // stall: nothing moves
        end else if (plan.size() != 0) begin
            m_state = plan.pop_front();
        end else begin
            m_state = IF_;
            m_ret   = m_ret + 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        chk("state",  bus.state,       m_state);
        chk("halted", bus.Halted,      m_halted);
        chk("illeg",  bus.IllegalOp,   m_illegal);
        chk("cycles", bus.CycleCount,  m_cyc);
        chk("retire", bus.RetireCount, m_ret);
    endtask

    task automatic step_exp(input logic [2:0] exp_state);
        step();
        chk("seq", bus.state, exp_state);
    endtask

    task automatic do_reset();
        Reset = 1; step(); Reset = 0;
    endtask

    initial begin
        Reset = 1; bus.opcode = 6'b000000; bus.InsReady = 0; bus.MemReady = 0; bus.Resume = 0;
        m_state = IF_; m_halted = 0; m_illegal = 0; m_cyc = 0; m_ret = 0;
        step(); step();
        Reset = 0;
        chk("rst_state", bus.state, 3'b000);
        chk("rst_cyc",   bus.CycleCount, 0);

        // add: 4-cycle instruction
        bus.InsReady = 1; bus.MemReady = 1; bus.opcode = 6'b000000;
        step_exp(ID_); step_exp(AEXE); step_exp(AWB); step_exp(IF_);
        chk("add_ret", bus.RetireCount, 1);
        chk("add_cyc", bus.CycleCount, 4);

        // lw with a 3-cycle data memory stall
        bus.opcode = 6'b110001; bus.MemReady = 0;
        step_exp(ID_); step_exp(CEXE); step_exp(MEM_);
        step_exp(MEM_); step_exp(MEM_); step_exp(MEM_);
        bus.MemReady = 1;
        step_exp(CWB); step_exp(IF_);
        chk("lw_ret", bus.RetireCount, 2);
        chk("lw_cyc", bus.CycleCount, 12);

        // beq then sw
        bus.opcode = 6'b110100;
        step_exp(ID_); step_exp(BEXE); step_exp(IF_);
        bus.opcode = 6'b110000;
        step_exp(ID_); step_exp(CEXE); step_exp(MEM_); step_exp(IF_);
        chk("bs_ret", bus.RetireCount, 4);

        // halt freezes the cycle counter until Resume
        do_reset();
        bus.opcode = 6'b111111;
        step_exp(ID_); step_exp(IF_);
        chk("halt_set", bus.Halted, 1);
        for (int i = 0; i < 10; i++) step_exp(IF_);
        chk("halt_cyc", bus.CycleCount, 2);
        bus.Resume = 1; step_exp(IF_); bus.Resume = 0;
        chk("resume", bus.Halted, 0);
        bus.opcode = 6'b000000;
        step_exp(ID_); step_exp(AEXE); step_exp(AWB); step_exp(IF_);

        // illegal opcode is sticky and does not retire
        bus.opcode = 6'b101010;
        step_exp(ID_); step_exp(IF_);
        chk("ill_set", bus.IllegalOp, 1);
        chk("ill_ret", bus.RetireCount, 2);
        bus.opcode = 6'b000000;
        step_exp(ID_); step_exp(AEXE); step_exp(AWB); step_exp(IF_);
        chk("ill_stick", bus.IllegalOp, 1);
        do_reset();
        chk("ill_clr", bus.IllegalOp, 0);

        // reset in the middle of a MEM stall
        bus.opcode = 6'b110001; bus.MemReady = 0;
        step(); step(); step(); step();
        chk("in_mem", bus.state, MEM_);
        do_reset();
        chk("mr_state", bus.state, 3'b000);
        chk("mr_ret", bus.RetireCount, 0);
        chk("mr_cyc", bus.CycleCount, 0);

        // cycle counter wrap
        force dut.cycle_q = '1;
        #1;
        release dut.cycle_q;
        m_cyc = '1;
        chk("preload", bus.CycleCount, 32'hFFFF_FFFF);
        step();
        chk("wrap", bus.CycleCount, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_state == IF_ && $urandom_range(0, 3) == 0)
                bus.opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                                         : legal_ops[$urandom_range(0, 15)];
            bus.InsReady = ($urandom_range(0, 3) != 0);
            bus.MemReady = ($urandom_range(0, 4) > 1);
            bus.Resume   = ($urandom_range(0, 9) == 0);
            Reset        = ($urandom_range(0, 199) == 0);
            step();
        end
        Reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
